// File: rtl/jtdd_snd_mixn_pkg.sv
// jtdd_snd_pkg: shared definitions for the sound mixer slice.
//   state_t    - mixer sequencing states (IDLE, MAC, OUT)
//   GAIN_FRAC  - number of fractional bits in the 4.4 gain format
//   GAIN_UNITY - gain code for x1.0
package jtdd_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int         GAIN_FRAC  = 4;
  localparam logic [7:0] GAIN_UNITY = 8'h10;

endpackage

// File: rtl/jtdd_snd_mixn_if.sv
// jtdd_snd_mixn_if: bus between a sample source / control host and the mixer.
//
// Handshake: there is no ready. cen is a one-cycle strobe that the mixer
// accepts only while idle; a strobe that lands while a mix is running is
// dropped and recorded in the sticky overrun flag. sample is a one-cycle
// valid that marks the cycle mixed takes its new value; mixed then holds
// until the next sample pulse.
//
//   cen        host -> mixer  start one mix (snapshot ch and gains)
//   ch         host -> mixer  CH packed signed channels, channel i at [i*WIN +: WIN]
//   gain_we    host -> mixer  gain write strobe
//   gain_addr  host -> mixer  channel index of the write (>= CH ignored)
//   gain_din   host -> mixer  gain value, unsigned 4.4
//   clr_flags  host -> mixer  clear clip/overrun
//   mixed      mixer -> host  saturated mix result
//   sample     mixer -> host  one-cycle pulse when mixed updates
//   clip       mixer -> host  sticky saturation flag
//   overrun    mixer -> host  sticky dropped-cen flag
//   dbg_state  mixer -> host  current sequencer state
interface jtdd_snd_mixn_if #(
  parameter int CH   = 4,
  parameter int WIN  = 16,
  parameter int WOUT = 16,
  parameter int GW   = 8
);
  logic                   cen;
  logic [CH*WIN-1:0]      ch;
  logic                   gain_we;
  logic [2:0]             gain_addr;
  logic [GW-1:0]          gain_din;
  logic                   clr_flags;
  logic signed [WOUT-1:0] mixed;
  logic                   sample;
  logic                   clip;
  logic                   overrun;
  jtdd_snd_pkg::state_t   dbg_state;

  modport master (
    output cen, ch, gain_we, gain_addr, gain_din, clr_flags,
    input  mixed, sample, clip, overrun, dbg_state
  );

  modport slave (
    input  cen, ch, gain_we, gain_addr, gain_din, clr_flags,
    output mixed, sample, clip, overrun, dbg_state
  );
endinterface

// File: rtl/jtdd_snd_sat.sv
// jtdd_snd_sat: signed saturation from WI bits down to WO bits (WI >= WO).
//   din     - signed input
//   dout    - din clamped to the signed WO-bit range
//   clipped - high when clamping changed the value
module jtdd_snd_sat #(
  parameter int WI = 21,
  parameter int WO = 16
) (
  input  logic signed [WI-1:0] din,
  output logic signed [WO-1:0] dout,
  output logic                 clipped
);

  // The value fits when every bit from the WO-1 sign position up is equal.
  logic [WI-WO:0] top_bits;
  assign top_bits = din[WI-1:WO-1];

  always_comb begin
    clipped = !((&top_bits) || !(|top_bits));
    if (!clipped) begin
      dout = din[WO-1:0];
    end else if (din[WI-1]) begin
      dout = {1'b1, {(WO-1){1'b0}}};
    end else begin
      dout = {1'b0, {(WO-1){1'b1}}};
    end
  end

endmodule

// File: rtl/jtdd_snd_mixn.sv
// jtdd_snd_mixn: CH-channel sound mixer with per-channel 4.4 gains.
// A cen strobe snapshots all channels and gains, one shared multiplier then
// accumulates ch[i]*gain[i] over CH cycles, and the sum is scaled by 1/16,
// saturated to WOUT bits and registered. Result appears CH+2 cycles after
// the cen cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - jtdd_snd_mixn_if slave modport (see interface header)
module jtdd_snd_mixn
  import jtdd_snd_pkg::*;
#(
  parameter int CH   = 4,
  parameter int WIN  = 16,
  parameter int WOUT = 16,
  parameter int GW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  jtdd_snd_mixn_if.slave   bus
);

  localparam int IW = $clog2(CH);
  localparam int AW = WIN + GW + $clog2(CH) + 1;  // worst-case sum fits
  localparam int PW = WIN + GW + 1;               // signed x zero-extended gain
  localparam int SW = AW - GAIN_FRAC;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic signed [AW-1:0]    acc;
  logic signed [WOUT-1:0]  mixed_q;
  logic                    sample_q;
  logic                    clip_q;
  logic                    overrun_q;

  logic [GW-1:0]           gain_q  [CH];
  logic [GW-1:0]           gain_nx [CH];
  logic [GW-1:0]           snap_g  [CH];
  logic signed [WIN-1:0]   snap_ch [CH];

  // Gain bank with the pending write already applied, so a write in the
  // same cycle as an accepted cen lands in the snapshot.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      gain_nx[i] = gain_q[i];
      if (bus.gain_we && bus.gain_addr == 3'(i)) gain_nx[i] = bus.gain_din;
    end
  end

  // Single multiplier, time-multiplexed by idx.
  logic signed [PW-1:0] op_a, op_b, prod;
  logic signed [AW-1:0] acc_nx;
  assign op_a   = PW'(snap_ch[idx]);
  assign op_b   = $signed(PW'({1'b0, snap_g[idx]}));
  assign prod   = op_a * op_b;
  assign acc_nx = acc + AW'(prod);

  // Dropping the fraction bits is an arithmetic shift right rounding to -inf.
  logic signed [SW-1:0]   acc_sh;
  logic signed [WOUT-1:0] sat_val;
  logic                   sat_clip;
  assign acc_sh = acc[AW-1:GAIN_FRAC];

  jtdd_snd_sat #(.WI(SW), .WO(WOUT)) u_sat (
    .din     (acc_sh),
    .dout    (sat_val),
    .clipped (sat_clip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      mixed_q   <= '0;
      sample_q  <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        gain_q[i]  <= GW'(GAIN_UNITY);
        snap_g[i]  <= GW'(GAIN_UNITY);
        snap_ch[i] <= '0;
      end
    end else begin
      sample_q <= 1'b0;
      for (int i = 0; i < CH; i++) gain_q[i] <= gain_nx[i];
      // Clear first; a set later in this block overrides it.
      if (bus.clr_flags) begin
        clip_q    <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (bus.cen) begin
            for (int i = 0; i < CH; i++) begin
              snap_ch[i] <= bus.ch[i*WIN +: WIN];
              snap_g[i]  <= gain_nx[i];
            end
            acc   <= '0;
            idx   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (bus.cen) overrun_q <= 1'b1;
          acc <= acc_nx;
          if (idx == IW'(CH-1)) begin
            state <= ST_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.cen) overrun_q <= 1'b1;
          if (sat_clip) clip_q <= 1'b1;
          mixed_q  <= sat_val;
          sample_q <= 1'b1;
          idx      <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mixed     = mixed_q;
  assign bus.sample    = sample_q;
  assign bus.clip      = clip_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_jtdd_snd_mixn.sv
module tb_jtdd_snd_mixn;
  import jtdd_snd_pkg::*;

  logic clk;
  logic rst_n;

  jtdd_snd_mixn_if #(.CH(4), .WIN(16), .WOUT(16), .GW(8)) bus ();

  jtdd_snd_mixn #(.CH(4), .WIN(16), .WOUT(16), .GW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_samples = 0;

  always @(negedge clk) if (bus.sample) n_samples++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input logic [15:0] a, b, c, d);
    bus.ch = {d, c, b, a};
  endtask

  task automatic write_gain(input logic [2:0] addr, input logic [7:0] val);
    bus.gain_we = 1'b1; bus.gain_addr = addr; bus.gain_din = val;
    step();
    bus.gain_we = 1'b0;
  endtask

  task automatic set_all_gains(input logic [7:0] val);
    for (int i = 0; i < 4; i++) write_gain(3'(i), val);
  endtask

  task automatic pulse_clr();
    bus.clr_flags = 1'b1;
    step();
    bus.clr_flags = 1'b0;
  endtask

  // Raise cen for one cycle; return the cycle count at which sample shows.
  task automatic run_mix(input string tag, output int lat);
    bus.cen = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        bus.cen = 1'b0;
        bus.gain_we = 1'b0;
        check({tag, "_state_mac"}, {30'b0, bus.dbg_state}, {30'b0, ST_MAC});
      end
      if (bus.sample) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic mix_check(input string tag, input logic [15:0] exp_mixed, input logic exp_clip);
    int lat;
    logic [15:0] exp_v;
    exp_q.push_back(exp_mixed);
    run_mix(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'd6);
    exp_v = exp_q.pop_front();
    check({tag, "_mixed"}, {16'h0, bus.mixed}, {16'h0, exp_v});
    check({tag, "_clip"}, {31'b0, bus.clip}, {31'b0, exp_clip});
    step();
    check({tag, "_sample_1cyc"}, {31'b0, bus.sample}, 32'd0);
    check({tag, "_hold"}, {16'h0, bus.mixed}, {16'h0, exp_v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst_n = 1'b0;
    bus.cen = 1'b0; bus.ch = '0; bus.gain_we = 1'b0; bus.gain_addr = '0;
    bus.gain_din = '0; bus.clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mixed",   {16'h0, bus.mixed}, 32'd0);
    check("rst_sample",  {31'b0, bus.sample}, 32'd0);
    check("rst_clip",    {31'b0, bus.clip}, 32'd0);
    check("rst_overrun", {31'b0, bus.overrun}, 32'd0);
    check("rst_state",   {30'b0, bus.dbg_state}, {30'b0, ST_IDLE});

    // Unity gains out of reset; cen on the first edge after release.
    set_ch(16'd100, 16'd200, -16'sd50, 16'd25);
    rst_n = 1'b1;
    mix_check("unity", 16'h0113, 1'b0);  // 275

    // Positive saturation, then clear.
    set_all_gains(8'h20);
    set_ch(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    mix_check("sat_pos", 16'h7FFF, 1'b1);
    pulse_clr();
    check("clip_cleared", {31'b0, bus.clip}, 32'd0);

    // Negative saturation.
    set_ch(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    mix_check("sat_neg", 16'h8000, 1'b1);
    pulse_clr();

    // Gain 0.5: -1*8 = -8 -> floor(-0.5) = -1; 1*8 = 8 -> 0.
    set_all_gains(8'h08);
    set_ch(16'hFFFF, 16'd0, 16'd0, 16'd0);
    mix_check("floor_neg", 16'hFFFF, 1'b0);
    set_ch(16'd1, 16'd0, 16'd0, 16'd0);
    mix_check("floor_pos", 16'h0000, 1'b0);

    // Second cen two cycles into the mix is dropped.
    set_all_gains(8'h10);
    set_ch(16'd1, 16'd2, 16'd3, 16'd4);
    base = n_samples;
    bus.cen = 1'b1;
    step();
    bus.cen = 1'b0;
    set_ch(16'd1000, 16'd1000, 16'd1000, 16'd1000);
    step();
    bus.cen = 1'b1;
    step();
    bus.cen = 1'b0;
    repeat (10) step();
    check("ovr_one_sample", 32'(n_samples - base), 32'd1);
    check("ovr_mixed",      {16'h0, bus.mixed}, 32'd10);
    check("ovr_flag",       {31'b0, bus.overrun}, 32'd1);

    // cen does not clear overrun.
    set_ch(16'd16, 16'd0, 16'd0, 16'd0);
    mix_check("ovr_keep", 16'h0010, 1'b0);
    check("ovr_sticky", {31'b0, bus.overrun}, 32'd1);
    pulse_clr();
    check("ovr_cleared", {31'b0, bus.overrun}, 32'd0);

    // Set beats clear in the same cycle.
    bus.cen = 1'b1;
    step();
    bus.cen = 1'b1; bus.clr_flags = 1'b1;
    step();
    bus.cen = 1'b0; bus.clr_flags = 1'b0;
    check("ovr_set_wins", {31'b0, bus.overrun}, 32'd1);
    repeat (8) step();
    pulse_clr();

    // Gain write coinciding with cen is used by that mix.
    set_ch(16'd100, 16'd200, 16'd0, 16'd0);
    bus.gain_we = 1'b1; bus.gain_addr = 3'd1; bus.gain_din = 8'h00;
    mix_check("gain_same_cyc", 16'h0064, 1'b0);  // 100
    write_gain(3'd5, 8'h00);
    set_ch(16'd100, 16'd200, 16'd300, 16'd400);
    mix_check("gain_addr_oob", 16'h0320, 1'b0);  // 100+0+300+400

    // Reset in the middle of a mix.
    set_ch(16'd16, 16'd16, 16'd16, 16'd16);
    base = n_samples;
    bus.cen = 1'b1;
    step();
    bus.cen = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_mixed", {16'h0, bus.mixed}, 32'd0);
    check("mid_rst_state", {30'b0, bus.dbg_state}, {30'b0, ST_IDLE});
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    check("mid_rst_no_sample", 32'(n_samples - base), 32'd0);

    // Gains back to unity (channel 1 had gain 0 before reset).
    set_ch(16'd16, 16'd0, 16'd0, 16'd0);
    mix_check("post_rst_a", 16'h0010, 1'b0);
    set_ch(16'd16, 16'd16, 16'd0, 16'd0);
    mix_check("post_rst_b", 16'h0020, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtdd_snd_mixn.md
JTDD_SND_MIXN -- requirements
Module: jtdd_snd_mixn

Interface
REQ-001 SHALL have parameter CH, default 4, meaning channel count (legal 2..8).
REQ-002 SHALL have parameter WIN, default 16, meaning per-channel signed input width (narrower sources sign-extended by instantiator).
REQ-003 SHALL have parameter WOUT, default 16, meaning signed mixed output width (WOUT <= WIN+4).
REQ-004 SHALL have parameter GW, default 8, meaning gain width, unsigned 4.4 fixed point.
REQ-005 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have cen  input  1  sample strobe, one-cycle pulse; starts one mix.
REQ-008 SHALL have ch  input  CH*WIN  packed signed channels; channel i at bits [i*WIN +: WIN].
REQ-009 SHALL have gain_we  input  1  gain write strobe.
REQ-010 SHALL have gain_addr  input  3  channel index for write; index >= CH ignored.
REQ-011 SHALL have gain_din  input  GW  gain value.
REQ-012 SHALL have clr_flags  input  1  clears sticky flags.
REQ-013 SHALL have mixed  output  WOUT  signed saturated mix, registered.
REQ-014 SHALL have sample  output  1  one-cycle pulse when mixed updates.
REQ-015 SHALL have clip  output  1  sticky: a mix saturated.
REQ-016 SHALL have overrun  output  1  sticky: cen arrived while busy.

Function
REQ-017 SHALL hold per-channel gain registers written on gain_we; write applies to the gain snapshot taken at the next accepted cen.
REQ-018 SHALL, on cen in IDLE, snapshot all ch inputs and all gains, clear accumulator, enter MAC with index 0.
REQ-019 SHALL in MAC perform one signed multiply-accumulate per cycle, acc += ch[i]*gain[i] (gain zero-extended), i = 0..CH-1, then enter OUT.
REQ-020 SHALL size the accumulator WIN+GW+clog2(CH)+1 bits; no intermediate overflow.
REQ-021 SHALL in OUT arithmetic-shift acc right by 4 (truncate toward -inf), saturate to WOUT range, register mixed, pulse sample, return to IDLE.
REQ-022 SHALL give latency cen -> sample of exactly CH+2 cycles; mixed valid in the same cycle sample is high.
REQ-023 SHALL set clip when saturation alters the value in OUT.
REQ-024 SHALL ignore cen while in MAC or OUT and set overrun; mix in progress unaffected.
REQ-025 SHALL, when gain_we and cen coincide in IDLE, snapshot the newly written gain.
REQ-026 SHALL clear clip/overrun on clr_clr_flags; a set event in the same cycle wins.
REQ-027 SHALL hold mixed stable between sample pulses.
REQ-028 SHALL treat clr_flags as the only clear; flags not cleared by cen.

Reset
REQ-029 SHALL on rst_n low asynchronously force: state IDLE, index 0, acc 0, mixed 0, sample 0, clip 0, overrun 0, all gains 0x10 (unity).
REQ-030 SHALL abandon a mix in progress when reset asserts; no sample pulse produced for it.
REQ-031 SHALL accept cen on the first clock edge after rst_n deasserts.

Structure
REQ-032 SHALL place in package jtdd_snd_pkg: state encoding (IDLE, MAC, OUT), GAIN_UNITY=0x10 constant, gain fraction bits=4.
REQ-033 SHALL implement saturation in sub-module jtdd_snd_sat (parametrised input/output width, returns value and clipped flag).
REQ-034 SHALL use one multiplier shared across channels (time-multiplexed), no per-channel multipliers.

Verification
REQ-035 SHALL cover: CH=4, gains unity, ch={100,200,-50,25}, cen -> sample at cycle 6, mixed=275, clip=0.
REQ-036 SHALL cover: gains all 0x20, ch all 0x7000, cen -> mixed=0x7FFF, clip=1; clr_flags -> clip=0.
REQ-037 SHALL cover: ch all -0x8000, gains 0x20 -> mixed=-0x8000, clip=1.
REQ-038 SHALL cover: cen, then cen again 2 cycles later -> overrun=1, exactly one sample pulse, result of first snapshot.
REQ-039 SHALL cover: gain_we addr 1 value 0x00 same cycle as cen, ch={100,200,0,0} -> mixed=100; gain_addr=5 write -> no gain changed.
REQ-040 SHALL cover: rst_n low at cycle 3 of MAC -> mixed=0, no sample; after release, gains read back unity via mix of ch={16,0,0,0} -> mixed=16.
